mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
Parametrised channel sequencer for ADG732-class parallel-addressed analog multiplexers. It replaces the fixed up-count scanner with run/stop control and up, down, manual and ping-pong modes. It has a runtime channel limit and dwell, and an explicit CS/WR write sequence with programmable setup, strobe and hold. It sits between the top-level control registers and the mux pins, and emits a settled-channel qualifier for downstream sampling logic.

Parameters:
CH_W, 5, width of the mux address bus
NUM_CH, 32, physical channel count; addresses 0..NUM_CH-1 are legal
DWELL_W, 24, width of the dwell counter and the dwell port
SETUP_CYC, 2, clk cycles with address and cs_n valid before wr_n falls (>=1)
WR_CYC, 2, clk cycles wr_n is held low (>=1)
HOLD_CYC, 1, clk cycles address and cs_n are held after wr_n rises (>=1)

Ports:
clk  in  1  system clock
rst  in  1  reset
run  in  1  level; 1 = sequence, 0 = stop after the current write completes
mode  in  2  00 up, 01 down, 10 manual, 11 ping-pong
ch_last  in  CH_W  highest channel scanned; values above NUM_CH-1 are clamped to NUM_CH-1
dwell  in  DWELL_W  clk cycles per channel in DWELL; 0 is treated as 1
manual_ch  in  CH_W  target channel for manual mode; clamped like ch_last
manual_stb  in  1  one-cycle request to load manual_ch
mux_a  out  CH_W  address to the mux
mux_cs_n  out  1  chip select, active low
mux_wr_n  out  1  write strobe, active low; the mux latches on its rising edge
mux_en_n  out  1  mux enable, active low
cur_ch  out  CH_W  channel currently latched in the mux
ch_valid  out  1  1 while in DWELL (channel settled)
ch_change  out  1  one-cycle pulse on DWELL entry
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset is synchronous and active-high on clk; the already-decided values are rst and clk. Under rst, outputs are: mux_a=0, cur_ch=0, mux_cs_n=1, mux_wr_n=1, mux_en_n=1, ch_valid=0, ch_change=0, busy=0. The FSM goes to IDLE, counters clear, the pending manual flag clears and the ping-pong direction is set to up.
- rst asserted mid-sequence aborts immediately. The next cycle shows the reset values, and no partial strobe continues.
- States:
  - IDLE: mux_en_n=1. run=1 moves to SETUP on the next cycle, with next_ch = start channel. The start channel is 0 for up and ping-pong, ch_last for down, and manual_ch for manual.
  - SETUP: mux_a=next_ch, mux_cs_n=0, mux_wr_n=1, for SETUP_CYC cycles, then STROBE.
  - STROBE: mux_wr_n=0 for WR_CYC cycles, then HOLD.
  - HOLD: mux_wr_n=1, mux_cs_n=0, mux_a unchanged, for HOLD_CYC cycles. On exit: cur_ch <= mux_a, go to DWELL.
  - DWELL: mux_cs_n=1, mux_en_n=0, ch_valid=1. ch_change=1 on the first DWELL cycle only. Lasts max(dwell,1) cycles. dwell is sampled on DWELL entry; a change mid-dwell applies to the next channel. On exit: run=0 goes to IDLE (mux_en_n returns to 1); otherwise compute next_ch and go to SETUP.
- Write sequence length is exactly SETUP_CYC+WR_CYC+HOLD_CYC cycles. mux_a is stable from the first SETUP cycle through the last HOLD cycle.
- run deasserted during SETUP, STROBE or HOLD: the sequence completes, one DWELL is executed, then IDLE.
- Next-channel rules:
  - up: cur_ch==ch_last wraps to 0, else +1.
  - down: cur_ch==0 wraps to ch_last, else -1.
  - ping-pong: reverses direction at 0 and ch_last, with no repeated endpoint. ch_last=0 stays at 0.
  - manual: cur_ch repeats unless a manual request is pending. In manual mode with no pending request, DWELL re-enters itself (no rewrite, no ch_change) until a request arrives or run=0.
  - If cur_ch > the clamped ch_last (ch_last lowered at runtime), the next channel is 0 for up and ping-pong, and ch_last for down.
- manual_stb in any state sets the pending flag and captures manual_ch. The pending request is consumed at the next DWELL exit, or at IDLE start. A later strobe overwrites the earlier one.
- mode is sampled only at next-channel computation. A mode change never corrupts a write sequence in progress.
- Address arithmetic is modulo within 0..ch_last and never produces an address >= NUM_CH.

Decomposition:
- Package mux_scan_pkg: state enum (IDLE, SETUP, STROBE, HOLD, DWELL), mode encodings (MODE_UP, MODE_DOWN, MODE_MANUAL, MODE_PINGPONG), and a clamp function.
- Sub-module mux_next_ch: combinational next-channel and direction computation from cur_ch, mode, ch_last, direction and the pending manual request. Verified standalone.

Test Plan:
- Defaults, up mode, ch_last=3, dwell=4, run=1 -> mux_a sequence 0,1,2,3,0. Each write shows cs_n low for 5 cycles with wr_n low on cycles 3-4. ch_change pulses once per channel; the period is 9 cycles.
- Down mode, ch_last=2 -> sequence 2,1,0,2. Ping-pong, ch_last=2 -> 0,1,2,1,0,1.
- Manual mode, manual_ch=7 strobed in IDLE, then run=1 -> one write of 7, then DWELL held indefinitely with no further ch_change. Strobe manual_ch=40 with NUM_CH=32 -> a write of 31.
- run dropped during STROBE of channel 5 -> the write completes, cur_ch=5, one DWELL runs, then IDLE with mux_en_n=1 and busy=0.
- rst asserted during STROBE -> the next cycle shows wr_n=1, cs_n=1, en_n=1, mux_a=0, busy=0. run held high afterwards restarts at channel 0.
- dwell=0, ch_last lowered from 10 to 4 while cur_ch=8 in up mode -> DWELL lasts 1 cycle and the next channel is 0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the analog-mux channel sequencer.
// State and mode encodings plus the channel clamp used on every channel input.
package mux_scan_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StDwell
    } state_e;

    localparam logic [1:0] MODE_UP       = 2'b00;
    localparam logic [1:0] MODE_DOWN     = 2'b01;
    localparam logic [1:0] MODE_MANUAL   = 2'b10;
    localparam logic [1:0] MODE_PINGPONG = 2'b11;

    // Limit a requested channel to the physical range 0..num_ch-1.
    function automatic int unsigned clamp_ch(input int unsigned ch, input int unsigned num_ch);
        return (ch >= num_ch) ? (num_ch - 1) : ch;
    endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Combinational next-channel / direction logic for the mux sequencer.
// i_ch_last and i_man_ch must already be clamped to the physical range.
module mux_next_ch
    import mux_scan_pkg::*;
#(
    parameter int unsigned CH_W = 5
) (
    input  logic [CH_W-1:0] i_cur_ch,
    input  logic [1:0]      i_mode,
    input  logic [CH_W-1:0] i_ch_last,
    input  logic            i_dir_up,
    input  logic            i_man_pend,
    input  logic [CH_W-1:0] i_man_ch,
    output logic [CH_W-1:0] o_next_ch,
    output logic            o_dir_up,
    output logic            o_rewrite
);

    logic w_over;
    logic w_at_last;
    logic w_at_zero;

    assign w_over    = (i_cur_ch > i_ch_last);
    assign w_at_last = (i_cur_ch == i_ch_last);
    assign w_at_zero = (i_cur_ch == '0);

    always_comb begin
        o_next_ch = i_cur_ch;
        o_dir_up  = i_dir_up;
        o_rewrite = 1'b1;
        case (i_mode)
            MODE_UP: begin
                o_next_ch = (w_over || w_at_last) ? '0 : i_cur_ch + CH_W'(1);
            end
            MODE_DOWN: begin
                o_next_ch = (w_over || w_at_zero) ? i_ch_last : i_cur_ch - CH_W'(1);
            end
            MODE_PINGPONG: begin
                if (w_over || (i_ch_last == '0)) begin
                    o_next_ch = '0;
                    o_dir_up  = 1'b1;
                end else if (i_dir_up) begin
                    // Turn around at the top without repeating the endpoint.
                    if (w_at_last) begin
                        o_next_ch = i_cur_ch - CH_W'(1);
                        o_dir_up  = 1'b0;
                    end else begin
                        o_next_ch = i_cur_ch + CH_W'(1);
                    end
                end else begin
                    if (w_at_zero) begin
                        o_next_ch = i_cur_ch + CH_W'(1);
                        o_dir_up  = 1'b1;
                    end else begin
                        o_next_ch = i_cur_ch - CH_W'(1);
                    end
                end
            end
            MODE_MANUAL: begin
                if (i_man_pend) begin
                    o_next_ch = i_man_ch;
                end else begin
                    o_rewrite = 1'b0;
                end
            end
            default: begin
                o_next_ch = '0;
            end
        endcase
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Channel sequencer for parallel-addressed analog muxes: CS/WR write sequence,
// dwell timing and up/down/manual/ping-pong channel stepping.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned CH_W      = 5,
    parameter int unsigned NUM_CH    = 32,
    parameter int unsigned DWELL_W   = 24,
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned WR_CYC    = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_run,
    input  logic [1:0]         i_mode,
    input  logic [CH_W-1:0]    i_ch_last,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic [CH_W-1:0]    i_manual_ch,
    input  logic               i_manual_stb,
    output logic [CH_W-1:0]    o_mux_a,
    output logic               o_mux_cs_n,
    output logic               o_mux_wr_n,
    output logic               o_mux_en_n,
    output logic [CH_W-1:0]    o_cur_ch,
    output logic               o_ch_valid,
    output logic               o_ch_change,
    output logic               o_busy
);

    localparam logic [DWELL_W-1:0] SetupLoad = DWELL_W'(SETUP_CYC - 1);
    localparam logic [DWELL_W-1:0] WrLoad    = DWELL_W'(WR_CYC - 1);
    localparam logic [DWELL_W-1:0] HoldLoad  = DWELL_W'(HOLD_CYC - 1);

    state_e              r_state;
    state_e              w_state_next;
    logic [DWELL_W-1:0]  r_cnt;
    logic [CH_W-1:0]     r_addr;
    logic [CH_W-1:0]     r_cur_ch;
    logic [CH_W-1:0]     r_man_ch;
    logic                r_man_pend;
    logic                r_dir_up;
    logic                r_first;

    logic [CH_W-1:0]     w_ch_last;
    logic [CH_W-1:0]     w_man_ch_in;
    logic [CH_W-1:0]     w_man_ch_eff;
    logic                w_man_pend_eff;
    logic [CH_W-1:0]     w_start_ch;
    logic [CH_W-1:0]     w_next_ch;
    logic                w_dir_next;
    logic                w_rewrite;
    logic                w_cnt_done;
    logic [DWELL_W-1:0]  w_dwell_load;
    logic                w_start;
    logic                w_dwell_exit;
    logic                w_consume;

    assign w_ch_last    = CH_W'(clamp_ch(32'(i_ch_last), NUM_CH));
    assign w_man_ch_in  = CH_W'(clamp_ch(32'(i_manual_ch), NUM_CH));
    // A strobe arriving on the consuming cycle is used directly, not lost.
    assign w_man_pend_eff = r_man_pend | i_manual_stb;
    assign w_man_ch_eff   = i_manual_stb ? w_man_ch_in : r_man_ch;
    assign w_cnt_done     = (r_cnt == '0);
    assign w_dwell_load   = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);

    always_comb begin
        case (i_mode)
            MODE_DOWN:   w_start_ch = w_ch_last;
            MODE_MANUAL: w_start_ch = w_man_pend_eff ? w_man_ch_eff : w_man_ch_in;
            default:     w_start_ch = '0;
        endcase
    end

    mux_next_ch #(
        .CH_W (CH_W)
    ) u_next_ch (
        .i_cur_ch   (r_cur_ch),
        .i_mode     (i_mode),
        .i_ch_last  (w_ch_last),
        .i_dir_up   (r_dir_up),
        .i_man_pend (w_man_pend_eff),
        .i_man_ch   (w_man_ch_eff),
        .o_next_ch  (w_next_ch),
        .o_dir_up   (w_dir_next),
        .o_rewrite  (w_rewrite)
    );

    assign w_start      = (r_state == StIdle) && i_run;
    assign w_dwell_exit = (r_state == StDwell) && w_cnt_done && (!i_run || w_rewrite);
    assign w_consume    = w_start || w_dwell_exit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (i_run) w_state_next = StSetup;
            StSetup:  if (w_cnt_done) w_state_next = StStrobe;
            StStrobe: if (w_cnt_done) w_state_next = StHold;
            StHold:   if (w_cnt_done) w_state_next = StDwell;
            StDwell: begin
                // Manual mode with nothing pending simply re-arms the dwell.
                if (w_cnt_done) begin
                    if (!i_run) begin
                        w_state_next = StIdle;
                    end else if (w_rewrite) begin
                        w_state_next = StSetup;
                    end
                end
            end
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        o_mux_cs_n  = 1'b1;
        o_mux_wr_n  = 1'b1;
        o_mux_en_n  = 1'b1;
        o_ch_valid  = 1'b0;
        o_ch_change = 1'b0;
        o_busy      = 1'b1;
        unique case (r_state)
            StIdle:   o_busy = 1'b0;
            StSetup:  o_mux_cs_n = 1'b0;
            StStrobe: begin
                o_mux_cs_n = 1'b0;
                o_mux_wr_n = 1'b0;
            end
            StHold:   o_mux_cs_n = 1'b0;
            // Switch is enabled only once the new address is latched.
            StDwell: begin
                o_mux_en_n  = 1'b0;
                o_ch_valid  = 1'b1;
                o_ch_change = r_first;
            end
            default:  o_busy = 1'b0;
        endcase
    end

    assign o_mux_a  = r_addr;
    assign o_cur_ch = r_cur_ch;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_cur_ch   <= '0;
            r_man_ch   <= '0;
            r_man_pend <= 1'b0;
            r_dir_up   <= 1'b1;
            r_first    <= 1'b0;
        end else begin
            if (i_manual_stb) begin
                r_man_ch <= w_man_ch_in;
            end
            if (w_consume) begin
                r_man_pend <= 1'b0;
            end else if (i_manual_stb) begin
                r_man_pend <= 1'b1;
            end

            unique case (r_state)
                StIdle: begin
                    if (i_run) begin
                        r_addr   <= w_start_ch;
                        r_cnt    <= SetupLoad;
                        r_dir_up <= 1'b1;
                    end
                end
                StSetup: begin
                    r_cnt <= w_cnt_done ? WrLoad : r_cnt - DWELL_W'(1);
                end
                StStrobe: begin
                    r_cnt <= w_cnt_done ? HoldLoad : r_cnt - DWELL_W'(1);
                end
                StHold: begin
                    if (w_cnt_done) begin
                        r_cnt    <= w_dwell_load;
                        r_cur_ch <= r_addr;
                        r_first  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end
                end
                StDwell: begin
                    r_first <= 1'b0;
                    if (w_cnt_done) begin
                        if (i_run && w_rewrite) begin
                            r_addr   <= w_next_ch;
                            r_dir_up <= w_dir_next;
                            r_cnt    <= SetupLoad;
                        end else begin
                            r_cnt <= w_dwell_load;
                        end
                    end else begin
                        r_cnt <= r_cnt - DWELL_W'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed self-checking bench for mux_scan_ctrl with hand-computed expectations.
module tb_mux_scan_ctrl;

    localparam int unsigned CH_W    = 6;
    localparam int unsigned DWELL_W = 24;

    logic               clk = 1'b0;
    logic               rst;
    logic               run;
    logic [1:0]         mode;
    logic [CH_W-1:0]    ch_last;
    logic [DWELL_W-1:0] dwell;
    logic [CH_W-1:0]    manual_ch;
    logic               manual_stb;
    logic [CH_W-1:0]    mux_a;
    logic               mux_cs_n;
    logic               mux_wr_n;
    logic               mux_en_n;
    logic [CH_W-1:0]    cur_ch;
    logic               ch_valid;
    logic               ch_change;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int nev;
    int ev_ch  [16];
    int ev_cyc [16];
    int base_cyc;
    int prev_cyc;
    int cnt_a;
    int cnt_b;

    mux_scan_ctrl #(
        .CH_W      (CH_W),
        .NUM_CH    (32),
        .DWELL_W   (DWELL_W),
        .SETUP_CYC (2),
        .WR_CYC    (2),
        .HOLD_CYC  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_run        (run),
        .i_mode       (mode),
        .i_ch_last    (ch_last),
        .i_dwell      (dwell),
        .i_manual_ch  (manual_ch),
        .i_manual_stb (manual_stb),
        .o_mux_a      (mux_a),
        .o_mux_cs_n   (mux_cs_n),
        .o_mux_wr_n   (mux_wr_n),
        .o_mux_en_n   (mux_en_n),
        .o_cur_ch     (cur_ch),
        .o_ch_valid   (ch_valid),
        .o_ch_change  (ch_change),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        manual_stb = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Tick until n ch_change pulses are seen or the budget runs out.
    task automatic collect(input int n, input int budget);
        nev = 0;
        for (int k = 0; k < budget && nev < n; k++) begin
            tick();
            if (ch_change === 1'b1 && nev < 16) begin
                ev_ch[nev]  = int'(cur_ch);
                ev_cyc[nev] = cyc;
                nev++;
            end
        end
        chk("collect_count", 32'(nev), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mode = 2'b00; ch_last = 6'd3; dwell = 24'd4; manual_ch = '0;
        do_reset();

        // Reset state.
        chk("rst_mux_a", 32'(mux_a), 0);
        chk("rst_cur_ch", 32'(cur_ch), 0);
        chk("rst_pins", 32'({mux_cs_n, mux_wr_n, mux_en_n}), 32'b111);
        chk("rst_flags", 32'({ch_valid, ch_change, busy}), 0);

        // Up mode, ch_last=3, dwell=4: write timing then sequence 0,1,2,3,0.
        run = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i <= 5) begin
                chk("up_cs_n", 32'(mux_cs_n), 0);
                chk("up_wr_n", 32'(mux_wr_n), (i == 3 || i == 4) ? 0 : 1);
                chk("up_addr", 32'(mux_a), 0);
            end
        end
        chk("up_first_change", 32'({ch_change, ch_valid, mux_en_n, mux_cs_n}), 32'b1101);
        chk("up_first_cur", 32'(cur_ch), 0);
        base_cyc = cyc;
        collect(4, 100);
        chk("up_seq1", 32'(ev_ch[0]), 1);
        chk("up_seq2", 32'(ev_ch[1]), 2);
        chk("up_seq3", 32'(ev_ch[2]), 3);
        chk("up_seq_wrap", 32'(ev_ch[3]), 0);
        chk("up_period0", 32'(ev_cyc[0] - base_cyc), 9);
        chk("up_period3", 32'(ev_cyc[3] - ev_cyc[2]), 9);
        run = 1'b0;
        tick(); tick(); tick();
        chk("up_stop_dwell", 32'({ch_valid, busy}), 32'b11);
        tick();
        chk("up_stop_idle", 32'({busy, mux_en_n, ch_valid}), 32'b010);

        // Down mode, ch_last=2.
        do_reset();
        mode = 2'b01; ch_last = 6'd2; run = 1'b1;
        collect(4, 100);
        chk("down_0", 32'(ev_ch[0]), 2);
        chk("down_1", 32'(ev_ch[1]), 1);
        chk("down_2", 32'(ev_ch[2]), 0);
        chk("down_3", 32'(ev_ch[3]), 2);

        // Ping-pong, ch_last=2.
        do_reset();
        mode = 2'b11; ch_last = 6'd2; run = 1'b1;
        collect(6, 150);
        chk("pp_0", 32'(ev_ch[0]), 0);
        chk("pp_1", 32'(ev_ch[1]), 1);
        chk("pp_2", 32'(ev_ch[2]), 2);
        chk("pp_3", 32'(ev_ch[3]), 1);
        chk("pp_4", 32'(ev_ch[4]), 0);
        chk("pp_5", 32'(ev_ch[5]), 1);

        // Manual: strobe 7 in IDLE, then run; dwell holds with no rewrite.
        do_reset();
        mode = 2'b10; ch_last = 6'd3; manual_ch = 6'd7; manual_stb = 1'b1;
        tick();
        manual_stb = 1'b0;
        run = 1'b1;
        collect(1, 40);
        chk("man_ch7", 32'(ev_ch[0]), 7);
        chk("man_addr7", 32'(mux_a), 7);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ch_change === 1'b1) cnt_a++;
            if (ch_valid === 1'b1 && mux_cs_n === 1'b1) cnt_b++;
        end
        chk("man_hold_changes", 32'(cnt_a), 0);
        chk("man_hold_valid", 32'(cnt_b), 60);
        manual_ch = 6'd40; manual_stb = 1'b1;
        tick();
        manual_stb = 1'b0;
        collect(1, 40);
        chk("man_clamp31", 32'(ev_ch[0]), 31);
        chk("man_addr31", 32'(mux_a), 31);

        // run dropped during STROBE of channel 5.
        do_reset();
        mode = 2'b00; ch_last = 6'd7; dwell = 24'd4; run = 1'b1;
        collect(5, 100);
        chk("drop_pre_ch4", 32'(ev_ch[4]), 4);
        for (int i = 0; i < 6; i++) tick();
        chk("drop_in_strobe", 32'({mux_wr_n, mux_cs_n}), 0);
        chk("drop_addr5", 32'(mux_a), 5);
        run = 1'b0;
        tick(); tick(); tick();
        chk("drop_dwell_change", 32'({ch_change, ch_valid}), 32'b11);
        chk("drop_cur5", 32'(cur_ch), 5);
        tick(); tick(); tick();
        chk("drop_last_dwell", 32'({ch_valid, busy}), 32'b11);
        tick();
        chk("drop_idle", 32'({busy, mux_en_n, ch_valid}), 32'b010);

        // rst asserted in STROBE of channel 2, run held high.
        do_reset();
        mode = 2'b00; ch_last = 6'd3; run = 1'b1;
        collect(2, 60);
        for (int i = 0; i < 6; i++) tick();
        chk("rst_mid_strobe", 32'({mux_wr_n, mux_a}), 32'd2);
        rst = 1'b1;
        tick();
        chk("rst_mid_pins", 32'({mux_wr_n, mux_cs_n, mux_en_n}), 32'b111);
        chk("rst_mid_addr", 32'(mux_a), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        rst = 1'b0;
        collect(1, 40);
        chk("rst_restart_ch0", 32'(ev_ch[0]), 0);

        // dwell=0 and ch_last lowered 10 -> 4 while on channel 8.
        do_reset();
        mode = 2'b00; ch_last = 6'd10; dwell = 24'd0; run = 1'b1;
        collect(9, 200);
        chk("d0_ch8", 32'(ev_ch[8]), 8);
        chk("d0_period", 32'(ev_cyc[8] - ev_cyc[7]), 6);
        prev_cyc = ev_cyc[8];
        ch_last = 6'd4;
        tick();
        chk("d0_dwell_one", 32'({ch_valid, mux_cs_n}), 0);
        chk("d0_next_addr", 32'(mux_a), 0);
        collect(1, 20);
        chk("d0_next_ch", 32'(ev_ch[0]), 0);
        chk("d0_next_period", 32'(ev_cyc[0] - prev_cyc), 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
